// File: rtl/uart_rx_capture_if.sv
// uart_rx_capture_if
// Byte delivery channel between the UART receive capture block and the
// debug command decoder. The receiver owns the holding register and the
// consumer acknowledges each byte with rx_ready.
//   rx_byte   captured byte, stable while rx_valid is high
//   rx_valid  holding register full
//   rx_ready  consumer takes the byte on a cycle where rx_valid && rx_ready
interface uart_rx_capture_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_byte,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_byte,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_capture.sv
// uart_rx_capture
// Receive side of the debugger UART. It takes the raw RX pin from the host,
// oversamples at 16x, samples each bit at its midpoint, checks the stop bit
// and hands validated bytes to the command decoder through a single-entry
// holding register.
//
// Ports:
//   iCE_CLK       system clock, all logic on posedge
//   rst           asynchronous active-high reset
//   RX            raw serial line, idle high, asynchronous to iCE_CLK
//   rx_if         byte channel (master side): rx_byte, rx_valid, rx_ready
//   is_receiving  high whenever the FSM is not in IDLE
//   frame_error   one-cycle pulse, stop bit sampled low
//   overrun       one-cycle pulse, byte completed while holding register full
//   parity_error  (RX_PARITY_EN only) one-cycle pulse, even parity mismatch
//
// Build option: define RX_PARITY_EN for 8E1 frames (adds a PARITY state and
// the parity_error port). Without it the receiver handles 8N1 only.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for synced RX low
// START     | qualifying the start bit, sampled at its midpoint
// DATA      | shifting in 8 data bits, LSB first
// PARITY    | (RX_PARITY_EN) sampling the even-parity bit
// STOP      | sampling the stop bit, delivering or discarding the byte
// WAIT_IDLE | after a framing error, holding until the line returns high
module uart_rx_capture #(
    parameter int BAUD_RATE    = 9600,
    parameter int SYS_CLK_FREQ = 12000000
) (
    input  logic              iCE_CLK,
    input  logic              rst,
    input  logic              RX,
    uart_rx_capture_if.master rx_if,
    output logic              is_receiving,
    output logic              frame_error,
    output logic              overrun
`ifdef RX_PARITY_EN
    ,
    output logic              parity_error
`endif
);

    localparam int TICK_DIV = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
`ifdef RX_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    state_t            state, state_nxt;
    logic              rx_meta, rx_sync;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [3:0]        os_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic [7:0]        rx_byte_q;
    logic              rx_valid_q;

    logic              half_pt, full_pt;
    logic              os_clr, shift_en, byte_done, frame_err_c;
`ifdef RX_PARITY_EN
    logic              par_bad, par_sample, par_err_c;
`endif

    assign tick         = (tick_cnt == TICK_LAST);
    // Start bit is qualified at its midpoint (8 ticks); after that every
    // 16 ticks lands in the middle of the next bit.
    assign half_pt      = tick && (os_cnt == 4'd7);
    assign full_pt      = tick && (os_cnt == 4'd15);
    assign is_receiving = (state != IDLE);
    assign rx_if.rx_byte  = rx_byte_q;
    assign rx_if.rx_valid = rx_valid_q;

    always_ff @(posedge iCE_CLK or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        os_clr      = 1'b0;
        shift_en    = 1'b0;
        byte_done   = 1'b0;
        frame_err_c = 1'b0;
`ifdef RX_PARITY_EN
        par_sample  = 1'b0;
        par_err_c   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_sync) state_nxt = START;
            end
            START: begin
                if (half_pt) begin
                    os_clr    = 1'b1;
                    state_nxt = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_pt) begin
                    shift_en = 1'b1;
`ifdef RX_PARITY_EN
                    if (bit_idx == 3'd7) state_nxt = PARITY;
`else
                    if (bit_idx == 3'd7) state_nxt = STOP;
`endif
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (full_pt) begin
                    par_sample = 1'b1;
                    state_nxt  = STOP;
                end
            end
`endif
            STOP: begin
                if (full_pt) begin
                    // A low stop bit wins over a parity mismatch.
                    if (!rx_sync) begin
                        frame_err_c = 1'b1;
                        state_nxt   = WAIT_IDLE;
                    end else begin
                        state_nxt = IDLE;
`ifdef RX_PARITY_EN
                        if (par_bad) par_err_c = 1'b1;
                        else         byte_done = 1'b1;
`else
                        byte_done = 1'b1;
`endif
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_sync) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCE_CLK or posedge rst) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            tick_cnt    <= '0;
            os_cnt      <= 4'd0;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;

            // Holding the divider at zero in IDLE aligns tick phase to the start edge.
            if (state == IDLE || tick) tick_cnt <= '0;
            else                       tick_cnt <= tick_cnt + 1'b1;

            if (state == IDLE || os_clr) os_cnt <= 4'd0;
            else if (tick)               os_cnt <= os_cnt + 4'd1;

            if (state == IDLE) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                shift_reg <= {rx_sync, shift_reg[7:1]};
                bit_idx   <= bit_idx + 3'd1;
            end

            frame_error <= frame_err_c;
            overrun     <= byte_done && rx_valid_q && !rx_if.rx_ready;
`ifdef RX_PARITY_EN
            if (par_sample) par_bad <= ^{shift_reg, rx_sync};
            parity_error <= par_err_c;
`endif

            // A byte completing on the acceptance cycle refills the register
            // directly, so rx_valid stays high.
            if (byte_done && (!rx_valid_q || rx_if.rx_ready)) begin
                rx_byte_q  <= shift_reg;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_if.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture
// Directed bench for uart_rx_capture. The baud rate is raised so that one
// bit is 256 clocks (tick divider 16) to keep run time short; glitch length
// is scaled to the same fraction of a bit as in the nominal 1248-clock case.
module tb_uart_rx_capture;

    localparam int SYS_CLK  = 12000000;
    localparam int BAUD     = 46875;
    localparam int BIT_CLKS = 256;

    logic iCE_CLK = 1'b0;
    logic rst;
    logic RX;
    logic is_receiving;
    logic frame_error;
    logic overrun;
`ifdef RX_PARITY_EN
    logic parity_error;
`endif

    uart_rx_capture_if rx_if ();

    uart_rx_capture #(
        .BAUD_RATE    (BAUD),
        .SYS_CLK_FREQ (SYS_CLK)
    ) dut (
        .iCE_CLK      (iCE_CLK),
        .rst          (rst),
        .RX           (RX),
        .rx_if        (rx_if),
        .is_receiving (is_receiving),
        .frame_error  (frame_error),
        .overrun      (overrun)
`ifdef RX_PARITY_EN
        ,
        .parity_error (parity_error)
`endif
    );

    always #5 iCE_CLK = ~iCE_CLK;

    int n_checks = 0;
    int n_errors = 0;

    int         acc_cnt   = 0;
    int         valid_cyc = 0;
    int         fe_cnt    = 0;
    int         ov_cnt    = 0;
    int         pe_cnt    = 0;
    logic [7:0] last_byte = 8'h00;

    always @(negedge iCE_CLK) begin
        if (rx_if.rx_valid) valid_cyc++;
        if (rx_if.rx_valid && rx_if.rx_ready) begin
            acc_cnt++;
            last_byte = rx_if.rx_byte;
        end
        if (frame_error) fe_cnt++;
        if (overrun)     ov_cnt++;
`ifdef RX_PARITY_EN
        if (parity_error) pe_cnt++;
`endif
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold_bit(input logic v);
        RX = v;
        repeat (BIT_CLKS) @(posedge iCE_CLK);
        #1;
    endtask

    task automatic send_tail(input logic [7:0] d, input logic stop_v);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef RX_PARITY_EN
        hold_bit(^d);
`endif
        hold_bit(stop_v);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        hold_bit(1'b0);
        send_tail(d, stop_v);
    endtask

`ifdef RX_PARITY_EN
    task automatic send_frame_badpar(input logic [7:0] d);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
        hold_bit(~(^d));
        hold_bit(1'b1);
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, v0, f0, o0, p0;

        rst = 1'b1;
        RX  = 1'b1;
        rx_if.rx_ready = 1'b0;
        repeat (3) @(posedge iCE_CLK);
        @(negedge iCE_CLK);
        check_val("rst_valid", rx_if.rx_valid, 0);
        check_val("rst_byte",  rx_if.rx_byte,  8'h00);
        check_val("rst_busy",  is_receiving,   0);
        check_val("rst_fe",    frame_error,    0);
        check_val("rst_ov",    overrun,        0);
        @(posedge iCE_CLK); #1;
        rst = 1'b0;
        hold_bit(1'b1);

        // Nominal 0xA5 with consumer ready.
        rx_if.rx_ready = 1'b1;
        a0 = acc_cnt; v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt;
        RX = 1'b0;
        repeat (2) @(posedge iCE_CLK);
        @(negedge iCE_CLK);
        check_val("nom_busy_sync", is_receiving, 0);
        @(posedge iCE_CLK);
        @(negedge iCE_CLK);
        check_val("nom_busy_start", is_receiving, 1);
        repeat (BIT_CLKS - 3) @(posedge iCE_CLK);
        #1;
        send_tail(8'hA5, 1'b1);
        check_val("nom_busy_end", is_receiving, 0);
        hold_bit(1'b1);
        check_val("nom_acc",   acc_cnt - a0,   1);
        check_val("nom_byte",  last_byte,      8'hA5);
        check_val("nom_vcyc",  valid_cyc - v0, 1);
        check_val("nom_fe",    fe_cnt - f0,    0);
        check_val("nom_ov",    ov_cnt - o0,    0);

        // Short glitch: false start, then a clean 0x3C.
        a0 = acc_cnt; f0 = fe_cnt;
        RX = 1'b0;
        repeat (60) @(posedge iCE_CLK);
        #1;
        hold_bit(1'b1);
        hold_bit(1'b1);
        check_val("gl_busy", is_receiving, 0);
        check_val("gl_acc",  acc_cnt - a0, 0);
        check_val("gl_fe",   fe_cnt - f0,  0);
        send_frame(8'h3C, 1'b1);
        hold_bit(1'b1);
        check_val("gl_acc2", acc_cnt - a0, 1);
        check_val("gl_byte", last_byte,    8'h3C);

        // Framing error on 0x55, line low for two bit times, then 0x0F.
        a0 = acc_cnt; v0 = valid_cyc; f0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        hold_bit(1'b0);
        check_val("fe_wait_busy", is_receiving,   1);
        check_val("fe_pulse",     fe_cnt - f0,    1);
        check_val("fe_nvalid",    valid_cyc - v0, 0);
        hold_bit(1'b1);
        hold_bit(1'b1);
        check_val("fe_idle", is_receiving, 0);
        send_frame(8'h0F, 1'b1);
        hold_bit(1'b1);
        check_val("fe_acc2", acc_cnt - a0, 1);
        check_val("fe_byte", last_byte,    8'h0F);

        // Overrun: 0x11 then 0x22 with consumer stalled.
        rx_if.rx_ready = 1'b0;
        a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        hold_bit(1'b1);
        check_val("ov_valid", rx_if.rx_valid, 1);
        check_val("ov_byte",  rx_if.rx_byte,  8'h11);
        check_val("ov_pulse", ov_cnt - o0,    1);
        // Framing error while full must not look like an overrun.
        send_frame(8'h55, 1'b0);
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b1);
        check_val("ovfe_pulse", fe_cnt - f0,   1);
        check_val("ovfe_ov",    ov_cnt - o0,   1);
        check_val("ovfe_byte",  rx_if.rx_byte, 8'h11);
        rx_if.rx_ready = 1'b1;
        @(posedge iCE_CLK);
        @(negedge iCE_CLK);
        check_val("ov_drop",     rx_if.rx_valid, 0);
        check_val("ov_acc",      acc_cnt - a0,   1);
        check_val("ov_acc_byte", last_byte,      8'h11);

        // Reset during bit 4 of 0xF0, then a clean 0x81.
        hold_bit(1'b1);
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b0);
        RX = 1'b1;
        repeat (BIT_CLKS / 2) @(posedge iCE_CLK);
        @(negedge iCE_CLK);
        check_val("rm_busy_pre", is_receiving, 1);
        rst = 1'b1;
        #1;
        check_val("rm_valid", rx_if.rx_valid, 0);
        check_val("rm_byte",  rx_if.rx_byte,  8'h00);
        check_val("rm_busy",  is_receiving,   0);
        check_val("rm_fe",    frame_error,    0);
        check_val("rm_ov",    overrun,        0);
        repeat (3) @(posedge iCE_CLK);
        #1;
        rst = 1'b0;
        hold_bit(1'b1);
        hold_bit(1'b1);
        a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'h81, 1'b1);
        hold_bit(1'b1);
        check_val("rm_acc",  acc_cnt - a0, 1);
        check_val("rm_rbyte", last_byte,   8'h81);
        check_val("rm_fe2",  fe_cnt - f0,  0);
        check_val("rm_ov2",  ov_cnt - o0,  0);

`ifdef RX_PARITY_EN
        a0 = acc_cnt; p0 = pe_cnt;
        send_frame(8'h07, 1'b1);
        hold_bit(1'b1);
        check_val("par_ok_acc",  acc_cnt - a0, 1);
        check_val("par_ok_byte", last_byte,    8'h07);
        check_val("par_ok_pe",   pe_cnt - p0,  0);
        a0 = acc_cnt; p0 = pe_cnt;
        send_frame_badpar(8'h07);
        hold_bit(1'b1);
        check_val("par_bad_pe",  pe_cnt - p0,  1);
        check_val("par_bad_acc", acc_cnt - a0, 0);
`else
        p0 = pe_cnt;
        check_val("no_par_pe", pe_cnt - p0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Receive-side companion to the UART transmit path in the debugger: takes the raw serial RX pin from the host and delivers validated bytes to the debug command logic.
- 16x oversampling, mid-bit sampling, framing-error detection.
- Single-entry holding register with valid/ready handshake and overrun flag.
- Sits between the board RX pin and the command decoder; no dependence on the shared uart core.

Parameters:
- BAUD_RATE, 9600, serial bit rate in bits/s.
- SYS_CLK_FREQ, 12000000, iCE_CLK frequency in Hz.
- TICK_DIV, SYS_CLK_FREQ/(BAUD_RATE*16) (=78, integer truncation), clocks per oversample tick; derived, not overridden.

Ports:
- iCE_CLK  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- RX  input  1  raw serial line, idle high, asynchronous to iCE_CLK.
- rx_byte  output  8  captured byte; stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready.
- is_receiving  output  1  high whenever FSM not in IDLE.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while holding register full.

Behaviour:
- Reset values:
  - rx_byte=0x00, rx_valid=0, is_receiving=0, frame_error=0, overrun=0.
  - Synchronizer flops=1, FSM=IDLE, all counters=0.
- Synchronizer: RX passes through 2 flops; the FSM uses the synced value only.
- Tick generator: counter 0..TICK_DIV-1, tick pulse at wrap. Counter is cleared on leaving IDLE so phase aligns to the start edge.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE -> START: synced RX=0.
- START: after 8 ticks, sample RX.
  - 1: false start, return to IDLE; no outputs.
  - 0: go to DATA; bit index=0, tick count=0.
- DATA: every 16 ticks, sample RX into shift register, LSB first. After bit 7, go to STOP.
- STOP: after 16 ticks, sample RX.
  - 1: byte complete, go to IDLE.
  - 0: frame_error pulse, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE: stay until synced RX=1, then go to IDLE. Holds a break condition without generating bytes.
- Delivery:
  - On byte complete with rx_valid=0: rx_byte<=shift, rx_valid<=1 on the next clock edge after the stop-bit sample.
  - Latency from RX start edge to rx_valid ≈ 2 sync + 9.5 bit periods.
- Handshake:
  - rx_valid falls the cycle after rx_valid&&rx_ready.
  - If a byte completes in the same cycle as acceptance, the new byte loads and rx_valid stays 1.
- Overrun: byte complete while rx_valid=1 and rx_ready=0 -> overrun pulse. The new byte is dropped; the held rx_byte is unchanged.
- Frame error with holding register full: frame_error only, no overrun.
- rst asserted mid-frame: immediate return to reset values. After release, RX low mid-frame is treated as a new start bit; resynchronisation relies on false-start and framing checks.

Optional Feature:
- Macro RX_PARITY_EN.
- Defined:
  - Extra PARITY state between DATA and STOP samples one even-parity bit.
  - Adds output parity_error (1 bit, one-cycle pulse, reset 0) on mismatch; the byte is discarded.
  - The FSM still checks the stop bit; frame_error takes priority if both fail.
- Undefined:
  - 8N1 only; no PARITY state; parity_error port absent.

Test Plan:
- Nominal byte: 8N1 frame 0xA5 at 1248 clocks/bit, rx_ready=1 -> rx_valid pulses one cycle with rx_byte=0xA5; no error pulses; is_receiving high from start edge+2 to stop sample.
- Glitch: RX low for 300 clocks, then high -> no rx_valid, no frame_error; FSM returns to IDLE; a following 0x3C frame is received correctly.
- Framing error: 0x55 frame with stop bit driven low, RX high 2 bit times later -> frame_error single pulse, rx_valid stays 0, FSM passes through WAIT_IDLE; the next 0x0F is received.
- Overrun: send 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_byte=0x11 held, overrun pulse at second stop sample. Assert rx_ready -> rx_valid drops the next cycle.
- Reset mid-frame: assert rst during bit 4 of 0xF0 -> all outputs 0 immediately. After release and a clean 0x81 frame -> rx_byte=0x81, no spurious errors.
- RX_PARITY_EN: 0x07 with even parity bit 1 -> accepted. Same frame with parity bit 0 -> parity_error pulse, no rx_valid.
